clock_time_core: RTL and testbench



---
 rtl/clock_time_core.sv | 193 +++++++++++++++++++
 tb/tb_clock_time_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_core.sv
// BCD hours:minutes:seconds timekeeper with RUN/SET modes, 12/24 h display and day-rollover pulse.
// Optional SET-mode field blinking is enabled by defining CLOCK_TIME_BLINK_EN.
module clock_time_core #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned INIT_HOUR     = 0,
    parameter int unsigned INIT_MIN      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       hour_mode,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [3:0] hr_l,
    output logic [3:0] hr_h,
    output logic       pm,
    output logic       set_active,
    output logic [1:0] sel_field,
    output logic       day_pulse,
    output logic [5:0] digit_blank
);

    localparam int unsigned PW       = $clog2(TICKS_PER_SEC);
    localparam logic [7:0]  INIT_HR  = {4'(INIT_HOUR / 10), 4'(INIT_HOUR % 10)};
    localparam logic [7:0]  INIT_MN  = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10)};
    localparam logic        INIT_PM  = (INIT_HOUR >= 12);

    typedef enum logic [0:0] {StRun, StSet} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
    logic          day_q, day_d;
    logic          tick;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)           return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                    return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)          return max;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                    return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign tick = (state_q == StRun) && (presc_q == PW'(TICKS_PER_SEC - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sel_d   = sel_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        day_d   = 1'b0;
        if (key_mode) begin
            // Mode toggle wins over every other key in the same cycle.
            state_d = (state_q == StRun) ? StSet : StRun;
            presc_d = '0;
            if (state_q == StRun) sel_d = 2'd0;
        end else if (state_q == StRun) begin
            if (tick) begin
                presc_d = '0;
                sec_d   = bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
                end
                day_d = (sec_q == 8'h59) && (min_q == 8'h59) && (hr_q == 8'h23);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            if (key_sel) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            if (key_inc ^ key_dec) begin
                case (sel_q)
                    2'd0:    sec_d = key_inc ? bcd_inc(sec_q, 8'h59) : bcd_dec(sec_q, 8'h59);
                    2'd1:    min_d = key_inc ? bcd_inc(min_q, 8'h59) : bcd_dec(min_q, 8'h59);
                    default: hr_d  = key_inc ? bcd_inc(hr_q, 8'h23) : bcd_dec(hr_q, 8'h23);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            presc_q <= '0;
            sel_q   <= 2'd0;
            sec_q   <= 8'h00;
            min_q   <= INIT_MN;
            hr_q    <= INIT_HR;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            day_q   <= day_d;
        end
    end

    // Display conversion from the internal 24 h hour.
    logic [4:0] hr_bin, hr_12;
    logic [7:0] hr_disp;

    always_comb begin
        hr_bin = {1'b0, hr_q[7:4]} * 5'd10 + {1'b0, hr_q[3:0]};
        if (hr_bin == 5'd0)      hr_12 = 5'd12;
        else if (hr_bin > 5'd12) hr_12 = hr_bin - 5'd12;
        else                     hr_12 = hr_bin;
        hr_disp = hr_q;
        if (hour_mode) begin
            if (hr_12 >= 5'd10) hr_disp = {4'd1, 4'(hr_12 - 5'd10)};
            else                hr_disp = {4'd0, hr_12[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sec_h, sec_l} <= 8'h00;
            {min_h, min_l} <= INIT_MN;
            {hr_h, hr_l}   <= INIT_HR;
            pm             <= INIT_PM;
        end else begin
            {sec_h, sec_l} <= sec_q;
            {min_h, min_l} <= min_q;
            {hr_h, hr_l}   <= hr_disp;
            pm             <= (hr_bin >= 5'd12);
        end
    end

    assign set_active = (state_q == StSet);
    assign sel_field  = sel_q;
    assign day_pulse  = day_q;

`ifdef CLOCK_TIME_BLINK_EN
    localparam int unsigned BLINK_TICKS = TICKS_PER_SEC / 4;
    localparam int unsigned BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          hidden_q, hidden_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        // Any edit restarts the phase so the field is visible while it is being changed.
        if (state_q == StRun || key_mode || key_sel || key_inc || key_dec) begin
            blink_cnt_d = '0;
            hidden_d    = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
            blink_cnt_d = '0;
            hidden_d    = ~hidden_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
        end
    end

    always_comb begin
        digit_blank = 6'b0;
        if (hidden_q && state_q == StSet) begin
            case (sel_q)
                2'd0:    digit_blank = 6'b000011;
                2'd1:    digit_blank = 6'b001100;
                default: digit_blank = 6'b110000;
            endcase
        end
    end
`else
    assign digit_blank = 6'b0;
`endif

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core: counting, rollover, SET editing, 12 h display and reset.
module tb_clock_time_core;

    localparam logic [3:0] MODE = 4'b1000;
    localparam logic [3:0] SEL  = 4'b0100;
    localparam logic [3:0] INC  = 4'b0010;
    localparam logic [3:0] DEC  = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_n1, key_mode, key_sel, key_inc, key_dec, hour_mode;
    logic [3:0] sec_l, sec_h, min_l, min_h, hr_l, hr_h;
    logic       pm, set_active, day_pulse;
    logic [1:0] sel_field;
    logic [5:0] digit_blank;
    logic [3:0] sec_l1, sec_h1, min_l1, min_h1, hr_l1, hr_h1;
    logic       pm1, set_active1, day_pulse1;
    logic [1:0] sel_field1;
    logic [5:0] digit_blank1;

    int tests = 0;
    int fails = 0;

    clock_time_core #(.TICKS_PER_SEC(4), .INIT_HOUR(0), .INIT_MIN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel),
        .key_inc(key_inc), .key_dec(key_dec), .hour_mode(hour_mode),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h), .hr_l(hr_l), .hr_h(hr_h),
        .pm(pm), .set_active(set_active), .sel_field(sel_field), .day_pulse(day_pulse),
        .digit_blank(digit_blank)
    );

    clock_time_core #(.TICKS_PER_SEC(4), .INIT_HOUR(23), .INIT_MIN(59)) dut1 (
        .clk(clk), .rst_n(rst_n1), .key_mode(1'b0), .key_sel(1'b0),
        .key_inc(1'b0), .key_dec(1'b0), .hour_mode(1'b0),
        .sec_l(sec_l1), .sec_h(sec_h1), .min_l(min_l1), .min_h(min_h1), .hr_l(hr_l1),
        .hr_h(hr_h1), .pm(pm1), .set_active(set_active1), .sel_field(sel_field1),
        .day_pulse(day_pulse1), .digit_blank(digit_blank1)
    );

    logic [7:0] hr0, min0, sec0, hr1, min1, sec1;
    assign hr0  = {hr_h, hr_l};
    assign min0 = {min_h, min_l};
    assign sec0 = {sec_h, sec_l};
    assign hr1  = {hr_h1, hr_l1};
    assign min1 = {min_h1, min_l1};
    assign sec1 = {sec_h1, sec_l1};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        {key_mode, key_sel, key_inc, key_dec} = k;
        cyc(1);
        {key_mode, key_sel, key_inc, key_dec} = 4'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst_n1 = 1'b0; hour_mode = 1'b0;
        {key_mode, key_sel, key_inc, key_dec} = 4'b0;
        cyc(2);
        check("rst_hr", hr0, 8'h00);
        check("rst_min", min0, 8'h00);
        check("rst_sec", sec0, 8'h00);
        check("rst_set", {7'b0, set_active}, 8'h00);
        check("rst_sel", {6'b0, sel_field}, 8'h00);
        check("rst_day", {7'b0, day_pulse}, 8'h00);
        check("rst_blank", {2'b0, digit_blank}, 8'h00);
        check("rst_pm", {7'b0, pm}, 8'h00);
        check("rst1_hr", hr1, 8'h23);
        check("rst1_min", min1, 8'h59);
        check("rst1_pm", {7'b0, pm1}, 8'h01);

        // Counting: first tick on the 4th edge, visible on the 5th.
        rst_n = 1'b1;
        cyc(4); check("cnt_e4", sec0, 8'h00);
        cyc(1); check("cnt_e5", sec0, 8'h01);
        cyc(3); check("cnt_e8", sec0, 8'h01);
        cyc(1); check("cnt_e9", sec0, 8'h02);
        cyc(232);
        check("cnt_min", min0, 8'h01);
        check("cnt_sec", sec0, 8'h00);
        check("cnt_hr", hr0, 8'h00);

        // Day rollover from 23:59:00.
        rst_n1 = 1'b1;
        cyc(237);
        check("roll_sec", sec1, 8'h59);
        check("roll_min", min1, 8'h59);
        check("roll_hr", hr1, 8'h23);
        check("roll_day_pre", {7'b0, day_pulse1}, 8'h00);
        cyc(3);
        check("roll_day", {7'b0, day_pulse1}, 8'h01);
        check("roll_pm_pre", {7'b0, pm1}, 8'h01);
        cyc(1);
        check("roll_day_post", {7'b0, day_pulse1}, 8'h00);
        check("roll_hr0", hr1, 8'h00);
        check("roll_min0", min1, 8'h00);
        check("roll_sec0", sec1, 8'h00);
        check("roll_pm0", {7'b0, pm1}, 8'h00);

        // SET: hour edit with wrap.
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        press(MODE);
        check("set_active", {7'b0, set_active}, 8'h01);
        check("set_sel0", {6'b0, sel_field}, 8'h00);
        press(SEL); press(SEL);
        check("set_sel2", {6'b0, sel_field}, 8'h02);
        press(DEC); cyc(1);
        check("hr_dec_wrap", hr0, 8'h23);
        press(INC); press(INC); cyc(1);
        check("hr_inc_wrap", hr0, 8'h01);
        check("hr_min_keep", min0, 8'h00);
        cyc(100);
        check("set_no_tick", sec0, 8'h00);
        check("set_hr_keep", hr0, 8'h01);
        check("set_no_day", {7'b0, day_pulse}, 8'h00);

        // SET: minute wrap, simultaneous keys, mode priority.
        press(SEL);
        check("sel_wrap", {6'b0, sel_field}, 8'h00);
        press(SEL);
        press(DEC); cyc(1);
        check("min_dec_wrap", min0, 8'h59);
        press(INC); cyc(1);
        check("min_inc_wrap", min0, 8'h00);
        check("min_no_carry", hr0, 8'h01);
        press(INC | DEC); cyc(1);
        check("inc_dec_same", min0, 8'h00);
        press(MODE | INC);
        check("mode_prio_run", {7'b0, set_active}, 8'h00);
        cyc(4);
        check("resume_e4", sec0, 8'h00);
        check("mode_prio_min", min0, 8'h00);
        cyc(1);
        check("resume_e5", sec0, 8'h01);
        check("resume_hr", hr0, 8'h01);

        // 12 h display.
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        press(MODE); press(SEL);
        repeat (5) press(INC);
        hour_mode = 1'b1; cyc(1);
        check("h12_00", hr0, 8'h12);
        check("h12_00_pm", {7'b0, pm}, 8'h00);
        check("h12_min", min0, 8'h05);
        hour_mode = 1'b0; cyc(1);
        check("h24_00", hr0, 8'h00);
        press(SEL);
        repeat (13) press(INC);
        hour_mode = 1'b1; cyc(1);
        check("h12_13", hr0, 8'h01);
        check("h12_13_pm", {7'b0, pm}, 8'h01);
        check("h12_13_min", min0, 8'h05);
        hour_mode = 1'b0; cyc(1);
        check("h24_13", hr0, 8'h13);
        press(DEC);
        hour_mode = 1'b1; cyc(1);
        check("h12_12", hr0, 8'h12);
        check("h12_12_pm", {7'b0, pm}, 8'h01);
        hour_mode = 1'b0;

        // Hour 07, blink phase, then reset from SET.
        repeat (5) press(DEC);
        check("blink_vis", {2'b0, digit_blank}, 8'h00);
        cyc(1);
        check("set_hr7", hr0, 8'h07);
`ifdef CLOCK_TIME_BLINK_EN
        check("blink_hide", {2'b0, digit_blank}, 8'h30);
        cyc(1);
        check("blink_show", {2'b0, digit_blank}, 8'h00);
`else
        check("blank_tied", {2'b0, digit_blank}, 8'h00);
`endif
        rst_n = 1'b0; #1;
        check("arst_set", {7'b0, set_active}, 8'h00);
        check("arst_sel", {6'b0, sel_field}, 8'h00);
        check("arst_hr", hr0, 8'h00);
        check("arst_min", min0, 8'h00);
        check("arst_blank", {2'b0, digit_blank}, 8'h00);
        cyc(1); rst_n = 1'b1;
        cyc(4);
        check("arst_presc_e4", sec0, 8'h00);
        cyc(1);
        check("arst_presc_e5", sec0, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
